// File: rtl/jedro_1_mem_arb_pkg.sv
// Shared types and constants for the jedro_1 instruction/data memory arbiter.
package jedro_1_mem_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_DM   = 2'd2
    } rd_owner_e;

    localparam int unsigned BYTE_OFS_BITS = 2;

    // Counter width able to hold 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/jedro_1_arb_streak_cnt.sv
// Counts consecutive data grants that starved a pending fetch and forces one
// fetch grant once the streak reaches MAX_DATA_STREAK.
module jedro_1_arb_streak_cnt
    import jedro_1_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic if_req_i,
    input  logic if_gnt_i,
    input  logic dm_gnt_i,
    output logic force_if_o
);

    localparam int unsigned CNT_W = cnt_width(MAX_DATA_STREAK);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_STREAK);

    logic [CNT_W-1:0] streak_d;
    logic [CNT_W-1:0] streak_q;

    // Next streak value: clear whenever fetch is idle or served, saturate at max.
    always_comb begin
        streak_d = streak_q;
        if (!if_req_i || if_gnt_i) begin
            streak_d = {CNT_W{1'b0}};
        end else if (dm_gnt_i && (streak_q != CNT_MAX)) begin
            streak_d = streak_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            streak_d = streak_q;
        end
    end

    // Streak register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            streak_q <= {CNT_W{1'b0}};
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_if_o = (streak_q == CNT_MAX);

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Arbitrates one single-port 1-cycle-latency RAM between jedro_1 fetch and data ports.
// Define JEDRO_1_ARB_ANTISTARVE_EN to bound fetch starvation under data contention.
module jedro_1_mem_arbiter
    import jedro_1_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned RAM_ADDR_WIDTH  = 10,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,

    input  logic                      if_req_i,
    input  logic [ADDR_WIDTH-1:0]     if_addr_i,
    output logic                      if_gnt_o,
    output logic                      if_rvalid_o,
    output logic [DATA_WIDTH-1:0]     if_rdata_o,

    input  logic                      dm_req_i,
    input  logic                      dm_we_i,
    input  logic [DATA_WIDTH/8-1:0]   dm_be_i,
    input  logic [ADDR_WIDTH-1:0]     dm_addr_i,
    input  logic [DATA_WIDTH-1:0]     dm_wdata_i,
    output logic                      dm_gnt_o,
    output logic                      dm_rvalid_o,
    output logic [DATA_WIDTH-1:0]     dm_rdata_o,

    output logic                      ram_en_o,
    output logic [DATA_WIDTH/8-1:0]   ram_we_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;
    localparam int unsigned WA_HI = RAM_ADDR_WIDTH + BYTE_OFS_BITS - 1;

    if ((DATA_WIDTH % 8) != 0 || MAX_DATA_STREAK < 1) begin : g_bad_param
        $error("jedro_1_mem_arbiter: invalid DATA_WIDTH or MAX_DATA_STREAK");
    end

    logic      force_if_s;
    logic      sel_if_s;
    logic      sel_dm_s;
    rd_owner_e rd_owner_d;
    rd_owner_e rd_owner_q;

`ifdef JEDRO_1_ARB_ANTISTARVE_EN
    jedro_1_arb_streak_cnt #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_streak_cnt (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .if_req_i   (if_req_i),
        .if_gnt_i   (sel_if_s),
        .dm_gnt_i   (sel_dm_s),
        .force_if_o (force_if_s)
    );
`else
    assign force_if_s = 1'b0;
`endif

    // Winner selection: data first unless a starved fetch is being forced; nothing in reset.
    always_comb begin
        sel_dm_s = 1'b0;
        sel_if_s = 1'b0;
        if (!rstn_i) begin
            sel_dm_s = 1'b0;
            sel_if_s = 1'b0;
        end else if (dm_req_i && !(if_req_i && force_if_s)) begin
            sel_dm_s = 1'b1;
        end else if (if_req_i) begin
            sel_if_s = 1'b1;
        end else begin
            sel_dm_s = 1'b0;
            sel_if_s = 1'b0;
        end
    end

    // Remember which port owns the read whose data returns next cycle.
    always_comb begin
        rd_owner_d = OWNER_NONE;
        if (sel_if_s) begin
            rd_owner_d = OWNER_IF;
        end else if (sel_dm_s && !dm_we_i) begin
            rd_owner_d = OWNER_DM;
        end else begin
            rd_owner_d = OWNER_NONE;
        end
    end

    // Read-owner register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rd_owner_q <= OWNER_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign if_gnt_o    = sel_if_s;
    assign dm_gnt_o    = sel_dm_s;
    assign ram_en_o    = sel_if_s | sel_dm_s;
    assign ram_we_o    = (sel_dm_s && dm_we_i) ? dm_be_i : {BE_W{1'b0}};
    assign ram_addr_o  = sel_dm_s ? dm_addr_i[WA_HI:BYTE_OFS_BITS] : if_addr_i[WA_HI:BYTE_OFS_BITS];
    assign ram_wdata_o = sel_dm_s ? dm_wdata_i : {DATA_WIDTH{1'b0}};

    // Responses are steered to the owner only; reset also masks a response already in flight.
    assign if_rvalid_o = rstn_i && (rd_owner_q == OWNER_IF);
    assign dm_rvalid_o = rstn_i && (rd_owner_q == OWNER_DM);
    assign if_rdata_o  = if_rvalid_o ? ram_rdata_i : {DATA_WIDTH{1'b0}};
    assign dm_rdata_o  = dm_rvalid_o ? ram_rdata_i : {DATA_WIDTH{1'b0}};

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[BYTE_OFS_BITS-1:0], dm_addr_i[BYTE_OFS_BITS-1:0],
                                if_addr_i[ADDR_WIDTH-1:WA_HI+1], dm_addr_i[ADDR_WIDTH-1:WA_HI+1]};

endmodule
